// File: rtl/sponge_pkg.sv
// Shared types and defaults for the sponge (Keccak) controller.
package sponge_pkg;

  localparam int unsigned NUM_ROUNDS_DEFAULT = 24;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB_WAIT,
    PERMUTE,
    SQUEEZE_WR,
    SQUEEZE_PERM
  } state_t;

  typedef enum logic [1:0] {
    SHA3_256,
    SHA3_512,
    SHAKE128,
    SHAKE256
  } mode_t;

endpackage

// File: rtl/sponge_round_counter.sv
// Round counter: 0..NUM_ROUNDS-ROUNDS_PER_CYCLE in steps of ROUNDS_PER_CYCLE, wraps after the final step.
module sponge_round_counter
  import sponge_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS       = NUM_ROUNDS_DEFAULT,
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned RIDX_W           = $clog2(NUM_ROUNDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              step_i,
  output logic [RIDX_W-1:0] idx_o,
  output logic              final_o
);

  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - ROUNDS_PER_CYCLE);
  localparam logic [RIDX_W-1:0] STEP     = RIDX_W'(ROUNDS_PER_CYCLE);

  logic [RIDX_W-1:0] cnt_q, cnt_d;

  assign idx_o   = cnt_q;
  assign final_o = (cnt_q == LAST_IDX);

  // Next count: clear wins over step; the final step wraps to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = final_o ? '0 : cnt_q + STEP;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sponge_ctrl_fsm.sv
// Sponge controller: sequences absorb, permute and squeeze for one message per start.
module sponge_ctrl_fsm
  import sponge_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS       = NUM_ROUNDS_DEFAULT,
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned OUT_CNT_W        = 16,
  parameter int unsigned RIDX_W           = $clog2(NUM_ROUNDS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  mode_t                mode,
  input  logic [OUT_CNT_W-1:0] out_blocks,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 absorb_en,
  output logic                 round_en,
  output logic [RIDX_W-1:0]    round_idx,
  output logic                 state_clr,
  output mode_t                mode_q,
  input  logic                 out_ready,
  output logic                 out_we,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  if ((ROUNDS_PER_CYCLE == 0) || ((NUM_ROUNDS % ROUNDS_PER_CYCLE) != 0)) begin : g_bad_rpc
    $error("sponge_ctrl_fsm: ROUNDS_PER_CYCLE must divide NUM_ROUNDS");
  end

  state_t                state_q, state_d;
  logic [OUT_CNT_W-1:0]  rem_q, rem_d;
  mode_t                 mode_lat_q, mode_lat_d;
  logic                  last_q, last_d;

  logic                  cnt_clr, cnt_step, cnt_final;
  logic [RIDX_W-1:0]     cnt_idx;

  sponge_round_counter #(
    .NUM_ROUNDS      (NUM_ROUNDS),
    .ROUNDS_PER_CYCLE(ROUNDS_PER_CYCLE),
    .RIDX_W          (RIDX_W)
  ) u_rcnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .step_i (cnt_step),
    .idx_o  (cnt_idx),
    .final_o(cnt_final)
  );

  assign busy      = !rst && (state_q != IDLE);
  assign round_idx = round_en ? cnt_idx : '0;
  assign mode_q    = rst ? SHA3_256 : mode_lat_q;

  // Next-state and per-cycle output decode; abort and reset override everything.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    mode_lat_d = mode_lat_q;
    last_d     = last_q;
    cnt_clr    = 1'b0;
    cnt_step   = 1'b0;
    in_ready   = 1'b0;
    absorb_en  = 1'b0;
    round_en   = 1'b0;
    state_clr  = 1'b0;
    out_we     = 1'b0;
    out_last   = 1'b0;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_clr  = 1'b1;
          mode_lat_d = mode;
          rem_d      = (out_blocks == '0) ? OUT_CNT_W'(1) : out_blocks;
          last_d     = 1'b0;
          cnt_clr    = 1'b1;
          state_d    = ABSORB_WAIT;
        end
      end
      ABSORB_WAIT: begin
        if (in_valid) begin
          in_ready  = 1'b1;
          absorb_en = 1'b1;
          round_en  = 1'b1;
          cnt_step  = 1'b1;
          last_d    = in_last;
          // A one-cycle permutation ends right here.
          if (cnt_final) begin
            state_d = in_last ? SQUEEZE_WR : ABSORB_WAIT;
          end else begin
            state_d = PERMUTE;
          end
        end
      end
      PERMUTE: begin
        round_en = 1'b1;
        cnt_step = 1'b1;
        if (cnt_final) begin
          state_d = last_q ? SQUEEZE_WR : ABSORB_WAIT;
        end
      end
      SQUEEZE_WR: begin
        if (out_ready) begin
          out_we = 1'b1;
          if (rem_q == OUT_CNT_W'(1)) begin
            out_last   = 1'b1;
            done       = 1'b1;
            mode_lat_d = SHA3_256;
            last_d     = 1'b0;
            state_d    = IDLE;
          end else begin
            rem_d   = rem_q - OUT_CNT_W'(1);
            cnt_clr = 1'b1;
            state_d = SQUEEZE_PERM;
          end
        end
      end
      SQUEEZE_PERM: begin
        round_en = 1'b1;
        cnt_step = 1'b1;
        if (cnt_final) begin
          state_d = SQUEEZE_WR;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      in_ready   = 1'b0;
      absorb_en  = 1'b0;
      round_en   = 1'b0;
      out_we     = 1'b0;
      out_last   = 1'b0;
      state_clr  = 1'b1;
      done       = 1'b1;
      cnt_clr    = 1'b1;
      cnt_step   = 1'b0;
      rem_d      = '0;
      last_d     = 1'b0;
      mode_lat_d = SHA3_256;
      state_d    = IDLE;
    end

    if (rst) begin
      in_ready  = 1'b0;
      absorb_en = 1'b0;
      round_en  = 1'b0;
      state_clr = 1'b0;
      out_we    = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
    end
  end

  // State, remaining-block count, latched mode and last-block flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      mode_lat_q <= SHA3_256;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      mode_lat_q <= mode_lat_d;
      last_q     <= last_d;
    end
  end

endmodule

// File: tb/tb_sponge_ctrl_fsm.sv
// Bench for sponge_ctrl_fsm: four instances (1, 2, 4, 24 rounds per cycle) checked against a message-level model.
module tb_sponge_ctrl_fsm;
  import sponge_pkg::*;

  localparam int NR = 24;
  localparam int NI = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  mode_t       mode = SHA3_256;
  logic [15:0] out_blocks = 16'd1;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready_w  [NI];
  logic        absorb_en_w [NI];
  logic        round_en_w  [NI];
  logic [4:0]  round_idx_w [NI];
  logic        state_clr_w [NI];
  mode_t       mode_q_w    [NI];
  logic        out_we_w    [NI];
  logic        out_last_w  [NI];
  logic        busy_w      [NI];
  logic        done_w      [NI];

  int n_chk = 0;
  int n_fail = 0;

  // Model: message progress per instance, in terms of rounds left and writes left.
  bit    m_ok   [NI];
  bit    m_act  [NI];
  int    m_perm [NI];
  bit    m_sq   [NI];
  int    m_wl   [NI];
  mode_t m_mode [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned RPC = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 24;
    sponge_ctrl_fsm #(
      .NUM_ROUNDS(24), .ROUNDS_PER_CYCLE(RPC), .OUT_CNT_W(16)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .out_blocks(out_blocks), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready_w[g]), .absorb_en(absorb_en_w[g]), .round_en(round_en_w[g]),
      .round_idx(round_idx_w[g]), .state_clr(state_clr_w[g]), .mode_q(mode_q_w[g]),
      .out_ready(out_ready), .out_we(out_we_w[g]), .out_last(out_last_w[g]),
      .busy(busy_w[g]), .done(done_w[g])
    );
  end

  function automatic int rpc_of(int k);
    case (k)
      0: return 1;
      1: return 2;
      2: return 4;
      default: return 24;
    endcase
  endfunction

  function automatic logic [14:0] outv(int k);
    return {in_ready_w[k], absorb_en_w[k], round_en_w[k], round_idx_w[k], state_clr_w[k],
            2'(mode_q_w[k]), out_we_w[k], out_last_w[k], busy_w[k], done_w[k]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Compare every instance against the model each cycle, then advance the model.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      int r, p, idx;
      logic ir, ab, re, sc, we, ol, bs, dn;
      logic [1:0] mq;
      logic [14:0] e;
      r = rpc_of(k);
      p = NR / r;
      ir = 0; ab = 0; re = 0; sc = 0; we = 0; ol = 0; bs = 0; dn = 0; mq = 2'd0; idx = 0;
      if (!rst) begin
        if (!m_act[k]) begin
          if (start && !abort) sc = 1;
        end else begin
          bs = 1;
          mq = 2'(m_mode[k]);
          if (abort) begin
            sc = 1; dn = 1;
          end else if (m_perm[k] > 0) begin
            re = 1; idx = (p - m_perm[k]) * r;
          end else if (!m_sq[k]) begin
            if (in_valid) begin ir = 1; ab = 1; re = 1; end
          end else if (out_ready) begin
            we = 1;
            if (m_wl[k] == 1) begin ol = 1; dn = 1; end
          end
        end
      end
      e = {ir, ab, re, 5'(idx), sc, mq, we, ol, bs, dn};
      if (rst || m_ok[k]) begin
        n_chk++;
        if (outv(k) !== e) begin
          n_fail++;
          $display("FAIL model inst%0d rpc=%0d t=%0t: got %h expected %h", k, r, $time, outv(k), e);
        end
      end
      if (rst) begin
        m_ok[k] = 1; m_act[k] = 0; m_mode[k] = SHA3_256;
      end else if (!m_act[k]) begin
        if (start && !abort) begin
          m_act[k] = 1; m_perm[k] = 0; m_sq[k] = 0; m_mode[k] = mode;
          m_wl[k] = (out_blocks == 16'd0) ? 1 : int'(out_blocks);
        end
      end else if (abort) begin
        m_act[k] = 0; m_mode[k] = SHA3_256;
      end else if (m_perm[k] > 0) begin
        m_perm[k]--;
      end else if (!m_sq[k]) begin
        if (in_valid) begin m_perm[k] = p - 1; m_sq[k] = in_last; end
      end else if (out_ready) begin
        if (m_wl[k] == 1) begin
          m_act[k] = 0; m_mode[k] = SHA3_256;
        end else begin
          m_wl[k]--; m_perm[k] = p;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One reset cycle, then one idle cycle; the caller's next cycle is cycle 0.
  task automatic do_reset();
    next_cycle();
    rst = 1; start = 0; abort = 0; in_valid = 0; in_last = 0; out_ready = 0;
    @(negedge clk);
    chk("reset_outputs", 32'(outv(0)), 32'd0);
    next_cycle();
    rst = 0;
    @(negedge clk);
    chk("idle_outputs", 32'(outv(3)), 32'd0);
  endtask

  task automatic begin_msg(input mode_t md, input logic [15:0] ob);
    next_cycle();
    start = 1; mode = md; out_blocks = ob; in_valid = 0; in_last = 0;
  endtask

  initial begin
    int we_cnt, re_cnt;

    // Single block, out_blocks=1, for all rounds-per-cycle settings.
    do_reset();
    begin_msg(SHAKE128, 16'd1);
    out_ready = 1;
    @(negedge clk);
    chk("t1_state_clr", 32'(state_clr_w[0]), 32'd1);
    for (int c = 1; c <= 26; c++) begin
      next_cycle();
      start = 0; in_valid = (c == 1); in_last = (c == 1);
      @(negedge clk);
      if (c == 1) chk("t1_absorb", 32'({in_ready_w[0], absorb_en_w[0]}), 32'd3);
      if (c == 1) chk("t1_mode_q", 32'(mode_q_w[0]), 32'd2);
      if (c <= 24) chk("t1_ridx_rpc1", 32'({round_en_w[0], round_idx_w[0]}), 32'(32 + c - 1));
      if (c <= 12) chk("t1_ridx_rpc2", 32'({round_en_w[1], round_idx_w[1]}), 32'(32 + 2 * (c - 1)));
      if (c <= 6) chk("t1_ridx_rpc4", 32'({round_en_w[2], round_idx_w[2]}), 32'(32 + 4 * (c - 1)));
      if (c == 7) chk("t1_we_rpc4", 32'(out_we_w[2]), 32'd1);
      if (c == 13) chk("t1_we_rpc2", 32'(out_we_w[1]), 32'd1);
      if (c == 2) chk("t1_done_rpc24", 32'({out_we_w[3], out_last_w[3], done_w[3]}), 32'd7);
      if (c == 25) chk("t1_done", 32'({out_we_w[0], out_last_w[0], done_w[0], round_idx_w[0]}), 32'h0e0);
      if (c == 26) chk("t1_busy_low", 32'(busy_w[0]), 32'd0);
    end

    // Three blocks back to back with in_valid held high.
    do_reset();
    begin_msg(SHA3_256, 16'd1);
    out_ready = 1;
    for (int c = 1; c <= 74; c++) begin
      next_cycle();
      start = 0; in_valid = (c <= 49); in_last = (c == 49);
      @(negedge clk);
      if (c == 1 || c == 25 || c == 49) chk("t2_in_ready", 32'(in_ready_w[0]), 32'd1);
      if (c == 24 || c == 26 || c == 48) chk("t2_no_ready", 32'(in_ready_w[0]), 32'd0);
      if (c == 72) chk("t2_no_we", 32'(out_we_w[0]), 32'd0);
      if (c == 73) chk("t2_we", 32'(out_we_w[0]), 32'd1);
    end

    // Three output blocks with backpressure before the second write.
    do_reset();
    begin_msg(SHA3_512, 16'd3);
    out_ready = 1;
    we_cnt = 0; re_cnt = 0;
    for (int c = 1; c <= 85; c++) begin
      next_cycle();
      start = 0; in_valid = (c == 1); in_last = (c == 1);
      out_ready = !(c >= 50 && c <= 54);
      @(negedge clk);
      we_cnt += int'(out_we_w[0]);
      if (c >= 26 && c <= 54) re_cnt += int'(round_en_w[0]);
      if (c == 25 || c == 55) chk("t3_mid_write", 32'({out_we_w[0], out_last_w[0]}), 32'd2);
      if (c == 80) chk("t3_last_write", 32'({out_we_w[0], out_last_w[0], done_w[0]}), 32'd7);
    end
    chk("t3_we_count", 32'(we_cnt), 32'd3);
    chk("t3_round_gap", 32'(re_cnt), 32'd24);

    // Abort at round 10, then a clean restart.
    do_reset();
    begin_msg(SHAKE256, 16'd1);
    out_ready = 1;
    we_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      in_valid = (c == 1 || c == 14); in_last = in_valid;
      abort = (c == 11); start = (c == 13);
      @(negedge clk);
      if (c <= 37) we_cnt += int'(out_we_w[0]);
      if (c == 10) chk("t5_ridx9", 32'(round_idx_w[0]), 32'd9);
      if (c == 11) chk("t5_abort", 32'({state_clr_w[0], done_w[0], round_en_w[0], out_we_w[0], busy_w[0]}), 32'h19);
      if (c == 12) chk("t5_busy_low", 32'(busy_w[0]), 32'd0);
      if (c == 14) chk("t5_restart", 32'(in_ready_w[0]), 32'd1);
      if (c == 38) chk("t5_restart_done", 32'({out_we_w[0], out_last_w[0], done_w[0]}), 32'd7);
    end
    chk("t5_no_we", 32'(we_cnt), 32'd0);

    // Reset while waiting in the squeeze write, then out_blocks=0.
    do_reset();
    begin_msg(SHA3_256, 16'd1);
    out_ready = 0;
    for (int c = 1; c <= 28; c++) begin
      next_cycle();
      start = 0; in_valid = (c == 1); in_last = (c == 1); rst = (c == 27);
      @(negedge clk);
      if (c == 26) chk("t6_wait_wr", 32'({busy_w[0], out_we_w[0]}), 32'd2);
      if (c == 27 || c == 28) chk("t6_rst_outputs", 32'(outv(0)), 32'd0);
    end
    begin_msg(SHAKE128, 16'd0);
    out_ready = 1;
    we_cnt = 0;
    for (int c = 1; c <= 28; c++) begin
      next_cycle();
      start = 0; in_valid = (c == 1); in_last = (c == 1);
      @(negedge clk);
      we_cnt += int'(out_we_w[0]);
      if (c == 25) chk("t6_zero_blocks", 32'({out_we_w[0], out_last_w[0]}), 32'd3);
    end
    chk("t6_we_count", 32'(we_cnt), 32'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      next_cycle();
      rst        = ($urandom_range(0, 499) == 0);
      start      = ($urandom_range(0, 7) == 0);
      abort      = ($urandom_range(0, 79) == 0);
      in_valid   = 1'($urandom_range(0, 1));
      in_last    = ($urandom_range(0, 2) == 0);
      out_ready  = ($urandom_range(0, 4) != 0);
      mode       = mode_t'(2'($urandom_range(0, 3)));
      out_blocks = ($urandom_range(0, 19) == 0) ? 16'hFFFF : 16'($urandom_range(0, 3));
    end

    next_cycle();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
